// File: rtl/debug_controller_if.sv
// Debug access bus and dump stream between the debug controller and the host side.
// The master side is the controller: it selects registers, addresses data memory
// and drives the valid/ready dump stream.
interface debug_controller_if #(
    parameter int WORD_SIZE = 18,
    parameter int ADDR_SIZE = 18
) ();
    logic [7:0]           dbg_reg_sel;
    logic [WORD_SIZE-1:0] dbg_reg_data;
    logic [ADDR_SIZE-1:0] dbg_mem_addr;
    logic [WORD_SIZE-1:0] dbg_mem_dout;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output dbg_reg_sel,
        input  dbg_reg_data,
        output dbg_mem_addr,
        input  dbg_mem_dout,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  dbg_reg_sel,
        output dbg_reg_data,
        input  dbg_mem_addr,
        output dbg_mem_dout,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/debug_controller.sv
// Run/halt/dump controller: sequences processor reset, detects a fresh
// wait_for_continue halt, streams registers then data memory to the host and
// releases the processor on a host continue request.
module debug_controller #(
    parameter int WORD_SIZE    = 18,
    parameter int ADDR_SIZE    = 18,
    parameter int NUM_REGS     = 8,
    parameter int DUMP_WORDS   = 64,
    parameter int RESET_CYCLES = 2,
    parameter bit DUMP_ON_HALT = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic continue_req,
    output logic proc_reset,
    input  logic wait_for_continue,
    output logic wait_continue_execution,
    output logic halted,
    output logic busy,
    debug_controller_if.master dbg
);

    // Index is one bit wider than the address so a full 2^ADDR_SIZE dump never wraps.
    localparam int IDX_W = ADDR_SIZE + 1;
    localparam int CNT_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(DUMP_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        DUMP_REG,
        DUMP_MEM_ADDR,
        DUMP_MEM_LOAD,
        DUMP_OUT,
        WAIT_HOST,
        CONTINUE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 mem_phase_q, mem_phase_d;
    logic                 armed_q, armed_d;
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            mem_phase_q <= 1'b0;
            armed_q     <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            mem_phase_q <= mem_phase_d;
            armed_q     <= armed_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next state plus counter, index, arm flag and captured dump word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        mem_phase_d = mem_phase_q;
        armed_d     = armed_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RESET_HOLD;
                    cnt_d   = '0;
                end
            end
            RESET_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    armed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                // Only a halt preceded by a low wait_for_continue counts, so a
                // flag still high from the previous halt cannot retrigger.
                if (armed_q && wait_for_continue) begin
                    state_d     = DUMP_ON_HALT ? DUMP_REG : WAIT_HOST;
                    idx_d       = '0;
                    mem_phase_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (!wait_for_continue) begin
                    armed_d = 1'b1;
                end
            end
            DUMP_REG: begin
                // Memory always follows, so a register word is never the last.
                out_data_d = dbg.dbg_reg_data;
                out_last_d = 1'b0;
                state_d    = DUMP_OUT;
            end
            DUMP_MEM_ADDR: begin
                state_d = DUMP_MEM_LOAD;
            end
            DUMP_MEM_LOAD: begin
                out_data_d = dbg.dbg_mem_dout;
                out_last_d = (idx_q == MEM_LAST);
                state_d    = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (dbg.out_ready) begin
                    out_last_d = 1'b0;
                    if (out_last_q) begin
                        state_d = WAIT_HOST;
                    end else if (!mem_phase_q && (idx_q == REG_LAST)) begin
                        mem_phase_d = 1'b1;
                        idx_d       = '0;
                        state_d     = DUMP_MEM_ADDR;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = mem_phase_q ? DUMP_MEM_ADDR : DUMP_REG;
                    end
                end
            end
            WAIT_HOST: begin
                if (continue_req) begin
                    state_d = CONTINUE;
                end
            end
            CONTINUE: begin
                state_d = RUN;
                armed_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state and dump index.
    always_comb begin
        proc_reset              = (state_q == IDLE) || (state_q == RESET_HOLD);
        wait_continue_execution = (state_q == CONTINUE);
        dbg.out_valid           = (state_q == DUMP_OUT);
        halted                  = (state_q == DUMP_REG) || (state_q == DUMP_MEM_ADDR) ||
                                  (state_q == DUMP_MEM_LOAD) || (state_q == DUMP_OUT) ||
                                  (state_q == WAIT_HOST);
        busy                    = (state_q != IDLE);
        dbg.out_data            = out_data_q;
        dbg.out_last            = out_last_q;
        // Address is presented for the whole DUMP_MEM_ADDR cycle so a registered
        // memory read returns the word during DUMP_MEM_LOAD.
        dbg.dbg_reg_sel         = mem_phase_q ? 8'd0 : 8'(idx_q);
        dbg.dbg_mem_addr        = mem_phase_q ? idx_q[ADDR_SIZE-1:0] : '0;
    end

endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
Synthesizable run/halt/dump controller for the processor core. It sequences processor reset and detects the processor's wait_for_continue halt. It then streams the register file and the first DUMP_WORDS data-memory words out on a valid/ready port, and releases the processor on a host continue request. This is the hardware counterpart of the bench-side reset/wait/print_state flow, usable on FPGA with a host link.

Parameters:
WORD_SIZE, 18, processor data word width
ADDR_SIZE, 18, data memory address width
NUM_REGS, 8, register-file entries dumped (1..2^8)
DUMP_WORDS, 64, data-memory words dumped from address 0 (1..2^ADDR_SIZE)
RESET_CYCLES, 2, cycles proc_reset is held after start (>=1)
DUMP_ON_HALT, 1, 1 = dump on each halt; 0 = skip dump and go directly to WAIT_HOST

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  host pulse: begin reset sequence and run
continue_req  in  1  host pulse: release halted processor
proc_reset  out  1  active-high reset to processor
wait_for_continue  in  1  processor halted flag
wait_continue_execution  out  1  one-cycle release pulse to processor
dbg_reg_sel  out  8  register index; dbg_reg_data is combinational on it
dbg_reg_data  in  WORD_SIZE  selected register value
dbg_mem_addr  out  ADDR_SIZE  data memory read address
dbg_mem_dout  in  WORD_SIZE  memory data, valid 1 cycle after dbg_mem_addr
out_data  out  WORD_SIZE  dump stream word
out_valid  out  1  dump word valid
out_last  out  1  marks final dump word
out_ready  in  1  host accepts word when out_valid & out_ready
halted  out  1  high in DUMP_* and WAIT_HOST states
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, RESET_HOLD, RUN, DUMP_REG, DUMP_MEM_ADDR, DUMP_MEM_LOAD, DUMP_OUT, WAIT_HOST, CONTINUE.
- Reset (reset_n=0, async): state IDLE; proc_reset=1; wait_continue_execution=0; out_valid=0; out_last=0; out_data=0; dbg_reg_sel=0; dbg_mem_addr=0; halted=0; busy=0; counters and arm flag cleared.
- IDLE: proc_reset=1. start sampled high -> RESET_HOLD with the cycle counter cleared. start is ignored in every other state.
- RESET_HOLD: proc_reset stays 1 for exactly RESET_CYCLES cycles, then -> RUN. proc_reset=0 from the first RUN cycle.
- RUN, arm flag: the flag is cleared on entry and set when wait_for_continue is sampled low.
- RUN, halt: if the arm flag is set and wait_for_continue=1, go to DUMP_REG (DUMP_ON_HALT=1) or WAIT_HOST (DUMP_ON_HALT=0). A wait_for_continue still high from the previous halt therefore never retriggers a halt.
- Dump order: registers 0..NUM_REGS-1, then memory 0..DUMP_WORDS-1. Total NUM_REGS+DUMP_WORDS words; out_last=1 only with the final word.
- DUMP_REG: capture dbg_reg_data at dbg_reg_sel=index into out_data -> DUMP_OUT.
- DUMP_MEM_ADDR: drive dbg_mem_addr -> DUMP_MEM_LOAD.
- DUMP_MEM_LOAD: capture dbg_mem_dout -> DUMP_OUT.
- DUMP_OUT: out_valid=1; out_data and out_last are held stable until the out_valid & out_ready handshake completes. On handshake, out_valid drops the next cycle and the index increments.
- After DUMP_OUT: next register, first/next memory word, or WAIT_HOST after the last word.
- Throughput: at most one word per 2 cycles (registers) or 3 cycles (memory). The index counter is ADDR_SIZE+1 bits wide, so there is no wrap at DUMP_WORDS = 2^ADDR_SIZE.
- WAIT_HOST: continue_req sampled high -> CONTINUE. continue_req is ignored in all other states, including mid-dump.
- CONTINUE: wait_continue_execution=1 for exactly one cycle -> RUN (arm flag cleared).
- Simultaneous events: start and continue_req in the same cycle act only per the current state. A halt is impossible during RESET_HOLD because wait_for_continue is not sampled there.
- Reset mid-operation: reset_n=0 during any state immediately forces all reset values, including dropping out_valid mid-dump. The processor is held in reset again. No partial dump resumes after reset.

Test Plan:
- reset_n=0 then 1, no start -> proc_reset=1, out_valid=0, busy=0 indefinitely; a continue_req pulse produces no wait_continue_execution.
- start pulse sampled at cycle N, RESET_CYCLES=2 -> proc_reset=1 through cycle N+2, 0 from cycle N+3; busy=1 from N+1.
- Halt with r[i]=0x100+i, mem[j]=j^0x3FFFF, out_ready=1 -> 72 words: 0x100..0x107, then 0x3FFFF,0x3FFFE,...,0x3FFC0; out_last only on word 72; halted=1 throughout.
- Same halt with out_ready toggling 1,0,0,1 -> identical 72-word sequence, no drops or duplicates; out_data/out_last stable while out_valid & !out_ready.
- continue_req in WAIT_HOST, processor holds wait_for_continue=1 for 3 more cycles, then drops it -> single one-cycle wait_continue_execution pulse, no second dump; the next rising halt produces a new 72-word dump.
- reset_n pulsed low at dump word 10 -> out_valid=0 and proc_reset=1 asynchronously; DUMP_ON_HALT=0 build halts -> WAIT_HOST with zero stream words.
